// File: rtl/seq_divider.sv
// Iterative RV32M divide/remainder unit (DIV, DIVU, REM, REMU).
// Restoring shift-subtract with one quotient bit per cycle and valid/ready handshakes on both sides.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state_q, state_d;
  logic             rem_sel_q, rem_sel_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic             is_signed;
  logic             div_zero;
  logic             overflow;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] quo_fixed;
  logic [WIDTH-1:0] rem_fixed;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rem_sel_q <= 1'b0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      quo_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      rem_sel_q <= rem_sel_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
    end
  end

  // quo_q starts as the dividend and fills with quotient bits from the LSB as dividend bits leave the MSB.
  // The partial remainder never reaches the divisor, so only the trial value needs the extra top bit.
  always_comb begin
    state_d   = state_q;
    rem_sel_d = rem_sel_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    result_d  = result_q;

    is_signed = ~op[0];
    div_zero  = (divisor == '0);
    overflow  = is_signed && (dividend == MIN_NEG) && (divisor == '1);
    trial     = {rem_q, quo_q[WIDTH-1]};
    diff      = trial - {1'b0, dvs_q};
    quo_fixed = q_neg_q ? -quo_q : quo_q;
    rem_fixed = r_neg_q ? -rem_q : rem_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          rem_sel_d = op[1];
          if (div_zero) begin
            result_d = op[1] ? dividend : '1;
            state_d  = DONE;
          end else if (overflow) begin
            result_d = op[1] ? '0 : MIN_NEG;
            state_d  = DONE;
          end else begin
            quo_d   = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
            dvs_d   = (is_signed && divisor[WIDTH-1]) ? -divisor : divisor;
            q_neg_d = is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg_d = is_signed && dividend[WIDTH-1];
            rem_d   = '0;
            cnt_d   = CW'(WIDTH - 1);
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (diff[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
        end else begin
          rem_d = diff[WIDTH-1:0];
        end
        quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      FIX: begin
        result_d = rem_sel_q ? rem_fixed : quo_fixed;
        state_d  = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = ~in_ready;
  assign out_valid = (state_q == DONE);
  assign result    = result_q;

endmodule
